// File: rtl/fx_mode_sync.sv
// Pixel-bus delay line plus frame-synchronous effect-mode controller for the false-colour stage.
// Mode changes only land on a VSync leading edge, so a frame never switches colour part-way.
module fx_mode_sync #(
    parameter int PIPE_STAGES = 2,
    parameter bit SYNC_POL    = 1'b1,
    parameter int AUTO_FRAMES = 60,
    parameter int MAX_MODE    = 1,
    parameter int RESET_MODE  = 0
) (
    input  logic        PixelClk,
    input  logic        aRst,
    input  logic [23:0] vid_pData_in,
    input  logic        vid_pVDE_in,
    input  logic        vid_pHSync_in,
    input  logic        vid_pVSync_in,
    input  logic [2:0]  mode_req,
    input  logic        mode_req_valid,
    input  logic        auto_en,
    output logic [23:0] vid_pData_out,
    output logic        vid_pVDE_out,
    output logic        vid_pHSync_out,
    output logic        vid_pVSync_out,
    output logic [2:0]  mode_out,
    output logic        mode_pending,
    output logic        mode_ack
);

    localparam int               CNT_W     = $clog2(AUTO_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(AUTO_FRAMES - 1);
    localparam logic [2:0]       MODE_MAX  = 3'(MAX_MODE);
    localparam logic [2:0]       MODE_RST  = 3'(RESET_MODE);
    localparam logic             SYNC_IDLE = ~SYNC_POL;
    localparam logic [26:0]      PIPE_RST  = {24'd0, 1'b0, SYNC_IDLE, SYNC_IDLE};

    // Each stage carries {data, vde, hsync, vsync} so all four stay aligned.
    logic [26:0] pipe_q [PIPE_STAGES];
    logic [26:0] pipe_d [PIPE_STAGES];

    always_comb begin
        pipe_d[0] = {vid_pData_in, vid_pVDE_in, vid_pHSync_in, vid_pVSync_in};
        for (int i = 1; i < PIPE_STAGES; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge PixelClk or posedge aRst) begin
        if (aRst) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                pipe_q[i] <= PIPE_RST;
            end
        end else begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign {vid_pData_out, vid_pVDE_out, vid_pHSync_out, vid_pVSync_out} = pipe_q[PIPE_STAGES-1];

    logic             vs_prev_q,   vs_prev_d;
    logic [2:0]       mode_q,      mode_d;
    logic [2:0]       pend_mode_q, pend_mode_d;
    logic             pending_q,   pending_d;
    logic             ack_q,       ack_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             frame_start;

    assign frame_start = (vid_pVSync_in == SYNC_POL) && (vs_prev_q != SYNC_POL);

    always_comb begin
        vs_prev_d   = vid_pVSync_in;
        mode_d      = mode_q;
        pend_mode_d = pend_mode_q;
        pending_d   = pending_q;
        ack_d       = 1'b0;
        cnt_d       = cnt_q;

        if (mode_req_valid) begin
            pend_mode_d = mode_req;
            pending_d   = 1'b1;
        end

        // A strobe coinciding with frame start bypasses the pending slot entirely.
        if (frame_start) begin
            if (mode_req_valid) begin
                mode_d    = mode_req;
                pending_d = 1'b0;
                cnt_d     = '0;
                ack_d     = 1'b1;
            end else if (pending_q) begin
                mode_d    = pend_mode_q;
                pending_d = 1'b0;
                cnt_d     = '0;
                ack_d     = 1'b1;
            end else if (auto_en) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    mode_d = (mode_q >= MODE_MAX) ? 3'd0 : mode_q + 3'd1;
                    ack_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        if (!auto_en) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge PixelClk or posedge aRst) begin
        if (aRst) begin
            vs_prev_q   <= SYNC_IDLE;
            mode_q      <= MODE_RST;
            pend_mode_q <= 3'd0;
            pending_q   <= 1'b0;
            ack_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            vs_prev_q   <= vs_prev_d;
            mode_q      <= mode_d;
            pend_mode_q <= pend_mode_d;
            pending_q   <= pending_d;
            ack_q       <= ack_d;
            cnt_q       <= cnt_d;
        end
    end

    assign mode_out     = mode_q;
    assign mode_pending = pending_q;
    assign mode_ack     = ack_q;

endmodule

// File: tb/tb_fx_mode_sync.sv
// Bench for fx_mode_sync: directed vector table, hand-written frame sequences and a
// randomized run checked against a delay-line / frame-event reference model.
module tb_fx_mode_sync;

    localparam int PIPE_STAGES = 2;
    localparam bit SYNC_POL    = 1'b1;
    localparam int AUTO_FRAMES = 3;
    localparam int MAX_MODE    = 1;
    localparam int RESET_MODE  = 0;
    localparam logic [26:0] RST_WORD = {24'd0, 1'b0, ~SYNC_POL, ~SYNC_POL};

    logic        clk = 1'b0;
    logic        aRst = 1'b1;
    logic [23:0] data_in = '0;
    logic        vde_in = 1'b0;
    logic        hs_in = 1'b0;
    logic        vs_in = 1'b0;
    logic [2:0]  req = '0;
    logic        req_valid = 1'b0;
    logic        auto_en = 1'b0;
    logic [23:0] data_out;
    logic        vde_out, hs_out, vs_out;
    logic [2:0]  mode_out;
    logic        mode_pending, mode_ack;

    fx_mode_sync #(
        .PIPE_STAGES(PIPE_STAGES), .SYNC_POL(SYNC_POL), .AUTO_FRAMES(AUTO_FRAMES),
        .MAX_MODE(MAX_MODE), .RESET_MODE(RESET_MODE)
    ) dut (
        .PixelClk(clk), .aRst(aRst),
        .vid_pData_in(data_in), .vid_pVDE_in(vde_in),
        .vid_pHSync_in(hs_in), .vid_pVSync_in(vs_in),
        .mode_req(req), .mode_req_valid(req_valid), .auto_en(auto_en),
        .vid_pData_out(data_out), .vid_pVDE_out(vde_out),
        .vid_pHSync_out(hs_out), .vid_pVSync_out(vs_out),
        .mode_out(mode_out), .mode_pending(mode_pending), .mode_ack(mode_ack)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: a history of input words and frame-level mode bookkeeping.
    logic [26:0] hist[$];
    int  m_mode, m_pend_val, m_frames;
    bit  m_pend, m_ack, m_vs_prev;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        hist.delete();
        m_mode = RESET_MODE; m_pend_val = 0; m_frames = 0;
        m_pend = 0; m_ack = 0; m_vs_prev = ~SYNC_POL;
    endfunction

    function automatic void model_edge();
        bit fs;
        fs = (vs_in == SYNC_POL) && (m_vs_prev != SYNC_POL);
        m_ack = 0;
        if (fs && (req_valid || m_pend)) begin
            m_mode   = req_valid ? int'(req) : m_pend_val;
            m_pend   = 0;
            m_frames = 0;
            m_ack    = 1;
        end else begin
            if (req_valid) begin
                m_pend = 1;
                m_pend_val = int'(req);
            end
            if (fs && auto_en) begin
                m_frames++;
                if (m_frames == AUTO_FRAMES) begin
                    m_frames = 0;
                    m_mode   = (m_mode >= MAX_MODE) ? 0 : m_mode + 1;
                    m_ack    = 1;
                end
            end
        end
        if (!auto_en) m_frames = 0;
        m_vs_prev = vs_in;
        hist.push_front({data_in, vde_in, hs_in, vs_in});
        if (hist.size() > PIPE_STAGES) void'(hist.pop_back());
    endfunction

    task automatic check_model();
        logic [26:0] exp_w;
        exp_w = (hist.size() >= PIPE_STAGES) ? hist[PIPE_STAGES-1] : RST_WORD;
        chk("pipe_data", 32'(data_out), 32'(exp_w[26:3]));
        chk("pipe_vde",  32'(vde_out),  32'(exp_w[2]));
        chk("pipe_hs",   32'(hs_out),   32'(exp_w[1]));
        chk("pipe_vs",   32'(vs_out),   32'(exp_w[0]));
        chk("model_mode",    32'(mode_out),     32'(m_mode));
        chk("model_pending", 32'(mode_pending), 32'(m_pend));
        chk("model_ack",     32'(mode_ack),     32'(m_ack));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic apply_reset();
        aRst = 1'b1;
        #2;
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_vde",  32'(vde_out), 32'd0);
        chk("rst_syncs", 32'({hs_out, vs_out}), 32'({~SYNC_POL, ~SYNC_POL}));
        chk("rst_mode", 32'(mode_out), 32'(RESET_MODE));
        chk("rst_pend_ack", 32'({mode_pending, mode_ack}), 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 aRst = 1'b0;
    endtask

    task automatic run_frame();
        vs_in = 1'b1;
        tick(); tick();
        vs_in = 1'b0;
        tick(); tick(); tick();
    endtask

    typedef struct {
        logic       vs;
        logic       rv;
        logic [2:0] rq;
        logic [2:0] m;
        logic       p;
        logic       a;
    } vec_t;

    vec_t tbl[20];
    int   auto_seq1[8] = '{0, 0, 1, 1, 1, 0, 0, 0};
    int   auto_seq2[3] = '{0, 0, 1};

    initial begin
        int acks;
        // Each row is one clock: {vsync, req_valid, req} -> {mode_out, pending, ack} after that edge.
        tbl[0]  = '{1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 3'd2, 3'd0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 3'd0, 3'd2, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 3'd0, 3'd2, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 3'd3, 3'd2, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 3'd1, 3'd2, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 3'd0, 3'd1, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 3'd0, 3'd1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 3'd0, 3'd1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 3'd0, 3'd0, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 3'd5, 3'd0, 1'b1, 1'b0};
        tbl[17] = '{1'b1, 1'b0, 3'd0, 3'd5, 1'b0, 1'b1};
        tbl[18] = '{1'b1, 1'b0, 3'd0, 3'd5, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 1'b0, 3'd0, 3'd5, 1'b0, 1'b0};

        model_reset();
        apply_reset();

        // Pixel 0x123456 with VDE sampled at edge 0 shows after edge 1.
        data_in = 24'h123456; vde_in = 1'b1;
        tick();
        chk("pipe_edge0_data", 32'(data_out), 32'd0);
        data_in = 24'h0; vde_in = 1'b0;
        tick();
        chk("pipe_edge1_data", 32'(data_out), 32'h123456);
        chk("pipe_edge1_vde",  32'(vde_out),  32'd1);
        tick();

        for (int i = 0; i < 20; i++) begin
            vs_in = tbl[i].vs; req_valid = tbl[i].rv; req = tbl[i].rq;
            tick();
            chk($sformatf("tbl%0d_mode", i), 32'(mode_out), 32'(tbl[i].m));
            chk($sformatf("tbl%0d_pend", i), 32'(mode_pending), 32'(tbl[i].p));
            chk($sformatf("tbl%0d_ack", i),  32'(mode_ack), 32'(tbl[i].a));
        end
        req_valid = 1'b0; vs_in = 1'b0;

        // Auto-cycle, then a pause that must restart the frame count.
        apply_reset();
        auto_en = 1'b1;
        tick(); tick();
        chk("auto_init", 32'(mode_out), 32'd0);
        for (int k = 0; k < 8; k++) begin
            run_frame();
            chk($sformatf("auto_a_f%0d", k + 1), 32'(mode_out), 32'(auto_seq1[k]));
        end
        auto_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            run_frame();
            chk($sformatf("auto_off_f%0d", k + 1), 32'(mode_out), 32'd0);
        end
        auto_en = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            run_frame();
            chk($sformatf("auto_b_f%0d", k + 1), 32'(mode_out), 32'(auto_seq2[k]));
        end
        auto_en = 1'b0;

        // VSync held active for 100 clocks: one frame start only.
        apply_reset();
        req_valid = 1'b1; req = 3'd2;
        tick();
        req_valid = 1'b0;
        tick();
        vs_in = 1'b1;
        acks = 0;
        for (int i = 0; i < 100; i++) begin
            req_valid = (i == 50); req = 3'd3;
            tick();
            if (mode_ack) acks++;
        end
        req_valid = 1'b0;
        chk("hold_acks", 32'(acks), 32'd1);
        chk("hold_mode", 32'(mode_out), 32'd2);
        chk("hold_pend", 32'(mode_pending), 32'd1);
        vs_in = 1'b0;
        tick(); tick();
        vs_in = 1'b1;
        tick();
        chk("hold_next_mode", 32'(mode_out), 32'd3);
        vs_in = 1'b0;
        tick();

        // Asynchronous reset mid-frame drops the pending request.
        req_valid = 1'b1; req = 3'd1;
        tick();
        req_valid = 1'b0;
        tick();
        chk("midrst_pend_before", 32'(mode_pending), 32'd1);
        #1 aRst = 1'b1;
        #1;
        chk("midrst_mode", 32'(mode_out), 32'(RESET_MODE));
        chk("midrst_pend", 32'(mode_pending), 32'd0);
        model_reset();
        @(posedge clk);
        #1 aRst = 1'b0;
        vs_in = 1'b1;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mode_ack) acks++;
        end
        chk("midrst_no_ack", 32'(acks), 32'd0);
        chk("midrst_mode_after", 32'(mode_out), 32'(RESET_MODE));
        vs_in = 1'b0;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 800; i++) begin
            if (i == 400) apply_reset();
            data_in   = 24'($urandom);
            vde_in    = 1'($urandom);
            hs_in     = 1'($urandom);
            if ($urandom_range(0, 5) == 0) vs_in = ~vs_in;
            req_valid = ($urandom_range(0, 9) == 0);
            req       = 3'($urandom);
            if ($urandom_range(0, 60) == 0) auto_en = ~auto_en;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
